// File: rtl/pool_window_feeder.sv
// Buffers one raster row pair and replays it as serial 2x2 windows
// (top-left, top-right, bottom-left, bottom-right) for a max pooler.
module pool_window_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  output logic              block_last,
  output logic              frame_last
);

  localparam int unsigned DEPTH  = 2 * IMG_W;
  localparam int unsigned CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PAIRS  = IMG_H / 2;
  localparam int unsigned PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

  typedef enum logic {S_FILL, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic                in_ready_q, in_ready_d;
  logic                valid_out_q, valid_out_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                block_last_q, block_last_d;
  logic                frame_last_q, frame_last_d;
  logic [DATA_W-1:0]   pix_buf_q [DEPTH];
  logic [DATA_W-1:0]   pix_buf_d [DEPTH];
  logic                accept_c;
  logic [CNT_W-1:0]    rd_addr_c;

  assign accept_c = valid_in && in_ready_q;

  // Window beat k -> buffer slot: 2*(k>>2) + k[0] + (k[1] ? IMG_W : 0)
  always_comb begin
    rd_addr_c = CNT_W'(((32'(rd_cnt_q) >> 2) << 1) + 32'(rd_cnt_q[0])
                       + (rd_cnt_q[1] ? IMG_W : 32'd0));
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    pair_d       = pair_q;
    in_ready_d   = in_ready_q;
    valid_out_d  = 1'b0;
    dout_d       = dout_q;
    block_last_d = 1'b0;
    frame_last_d = 1'b0;
    pix_buf_d    = pix_buf_q;
    case (state_q)
      S_FILL: begin
        if (accept_c) begin
          pix_buf_d[wr_cnt_q] = din;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d   = '0;
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        valid_out_d  = 1'b1;
        dout_d       = pix_buf_q[rd_addr_c];
        block_last_d = (rd_cnt_q[1:0] == 2'b11);
        frame_last_d = (rd_cnt_q == LAST_IDX) && (pair_q == LAST_PAIR);
        if (rd_cnt_q == LAST_IDX) begin
          // Reopen input on the same edge that registers the final beat
          rd_cnt_d   = '0;
          state_d    = S_FILL;
          in_ready_d = 1'b1;
          pair_d     = (pair_q == LAST_PAIR) ? '0 : pair_q + PAIR_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      pair_q       <= '0;
      in_ready_q   <= 1'b1;
      valid_out_q  <= 1'b0;
      dout_q       <= '0;
      block_last_q <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      pair_q       <= pair_d;
      in_ready_q   <= in_ready_d;
      valid_out_q  <= valid_out_d;
      dout_q       <= dout_d;
      block_last_q <= block_last_d;
      frame_last_q <= frame_last_d;
    end
  end

  // Pixel storage carries no reset; stale contents are always overwritten before use
  always_ff @(posedge clk) begin
    pix_buf_q <= pix_buf_d;
  end

  assign in_ready   = in_ready_q;
  assign valid_out  = valid_out_q;
  assign dout       = dout_q;
  assign block_last = block_last_q;
  assign frame_last = frame_last_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: window order, handshake, framing and reset abort.
module tb_pool_window_feeder;

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] dout;
    logic        bl;
    logic        fl;
  } vec_t;

  logic clk;
  logic rst_n;
  // Instances a (4x2) and c (4x4) share one input stream
  logic        va;
  logic [15:0] din_w;
  logic        a_rdy, a_vo, a_bl, a_fl;
  logic [15:0] a_dout;
  logic        c_rdy, c_vo, c_bl, c_fl;
  logic [15:0] c_dout;
  logic        b_vin, b_rdy, b_vo, b_bl, b_fl;
  logic [15:0] b_din, b_dout;

  int checks;
  int errors;
  int c_fl_cnt;
  bit c_pair;
  vec_t tab_a  [8];
  vec_t tab_bp [8];
  vec_t tab_b  [4];
  vec_t cur    [8];
  logic signed [15:0] maxv;

  pool_window_feeder #(.DATA_W(16), .IMG_W(4), .IMG_H(2)) u_a (
    .clk(clk), .reset(rst_n), .valid_in(va), .in_ready(a_rdy), .din(din_w),
    .dout(a_dout), .valid_out(a_vo), .block_last(a_bl), .frame_last(a_fl));

  pool_window_feeder #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_c (
    .clk(clk), .reset(rst_n), .valid_in(va), .in_ready(c_rdy), .din(din_w),
    .dout(c_dout), .valid_out(c_vo), .block_last(c_bl), .frame_last(c_fl));

  pool_window_feeder #(.DATA_W(16), .IMG_W(2), .IMG_H(2)) u_b (
    .clk(clk), .reset(rst_n), .valid_in(b_vin), .in_ready(b_rdy), .din(b_din),
    .dout(b_dout), .valid_out(b_vo), .block_last(b_bl), .frame_last(b_fl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (c_vo && c_fl) c_fl_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_a_c(input string tag);
    chk({tag, "_a_rdy"}, a_rdy, 1);
    chk({tag, "_a_vo"}, a_vo, 0);
    chk({tag, "_a_dout"}, a_dout, 0);
    chk({tag, "_a_bl"}, a_bl, 0);
    chk({tag, "_a_fl"}, a_fl, 0);
    chk({tag, "_c_rdy"}, c_rdy, 1);
    chk({tag, "_c_vo"}, c_vo, 0);
    chk({tag, "_c_dout"}, c_dout, 0);
  endtask

  task automatic feed(input int start, input bit bubbles);
    for (int i = start; i < 8; i++) begin
      va = 1'b1;
      din_w = cur[i].din;
      @(posedge clk); #1;
      if (bubbles && i < 7) begin
        va = 1'b0;
        din_w = 16'hDEAD;
        @(posedge clk); #1;
        chk("fill_rdy", a_rdy, 1);
        chk("fill_vo", a_vo, 0);
      end
    end
  endtask

  // Called #1 after the edge that accepted the pair's last pixel
  task automatic drain(input bit hold, input int abort_after);
    chk("rdy_drop", a_rdy, 0);
    if (hold) begin
      va = 1'b1;
      din_w = 16'h7FFF;
    end else begin
      va = 1'b0;
    end
    chk("gap_vo", a_vo, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("beat_vo", a_vo, 1);
      chk("beat_dout", a_dout, cur[k].dout);
      chk("beat_bl", a_bl, cur[k].bl);
      chk("beat_fl_a", a_fl, cur[k].fl);
      chk("beat_dout_c", c_dout, cur[k].dout);
      chk("beat_fl_c", c_fl, cur[k].fl && c_pair);
      chk("beat_rdy", a_rdy, k == 7);
      if (k == abort_after) begin
        #3 rst_n = 1'b0;
        va = 1'b0;
        #1;
        chk_reset_a_c("abort");
        c_pair = 1'b0;
        return;
      end
    end
    c_pair = ~c_pair;
    @(posedge clk); #1;
    chk("post_vo", a_vo, 0);
    chk("post_hold", a_dout, cur[7].dout);
    chk("post_bl", a_bl, 0);
    chk("post_fl", a_fl, 0);
    va = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    c_fl_cnt = 0;
    c_pair = 1'b0;
    rst_n = 1'b0;
    va = 1'b0;
    din_w = '0;
    b_vin = 1'b0;
    b_din = '0;

    tab_a[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0};
    tab_a[1] = '{16'h0002, 16'h0002, 1'b0, 1'b0};
    tab_a[2] = '{16'h0003, 16'h0005, 1'b0, 1'b0};
    tab_a[3] = '{16'h0004, 16'h0006, 1'b1, 1'b0};
    tab_a[4] = '{16'h0005, 16'h0003, 1'b0, 1'b0};
    tab_a[5] = '{16'h0006, 16'h0004, 1'b0, 1'b0};
    tab_a[6] = '{16'h0007, 16'h0007, 1'b0, 1'b0};
    tab_a[7] = '{16'h0008, 16'h0008, 1'b1, 1'b1};

    tab_bp[0] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tab_bp[1] = '{16'h0011, 16'h0011, 1'b0, 1'b0};
    tab_bp[2] = '{16'h0012, 16'h0014, 1'b0, 1'b0};
    tab_bp[3] = '{16'h0013, 16'h0015, 1'b1, 1'b0};
    tab_bp[4] = '{16'h0014, 16'h0012, 1'b0, 1'b0};
    tab_bp[5] = '{16'h0015, 16'h0013, 1'b0, 1'b0};
    tab_bp[6] = '{16'h0016, 16'h0016, 1'b0, 1'b0};
    tab_bp[7] = '{16'h0017, 16'h0017, 1'b1, 1'b1};

    tab_b[0] = '{16'h0080, 16'h0080, 1'b0, 1'b0};
    tab_b[1] = '{16'h0133, 16'h0133, 1'b0, 1'b0};
    tab_b[2] = '{16'hFFB4, 16'hFFB4, 1'b0, 1'b0};
    tab_b[3] = '{16'h00CC, 16'h00CC, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_a_c("rst");
    chk("rst_b_rdy", b_rdy, 1);
    chk("rst_b_vo", b_vo, 0);
    rst_n = 1'b1;

    // Contiguous 1..8 while valid_in stays high with 0x7FFF through the drain
    cur = tab_a;
    feed(0, 1'b0);
    drain(1'b1, -1);
    // 0x7FFF was taken as pixel 0 when the final beat appeared
    cur = tab_bp;
    feed(1, 1'b0);
    drain(1'b0, -1);
    // Bubbles between every accepted pixel
    cur = tab_a;
    feed(0, 1'b1);
    drain(1'b0, -1);
    feed(0, 1'b0);
    drain(1'b0, -1);
    chk("c_frame_last_count", 32'(c_fl_cnt), 2);

    // Asynchronous abort after drain beat 3
    feed(0, 1'b0);
    drain(1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a_c("held");
    rst_n = 1'b1;
    feed(0, 1'b0);
    drain(1'b0, -1);
    chk("c_frame_last_after_rst", 32'(c_fl_cnt), 2);

    // Q8.8 values through a 2x2 image, then a pooled max
    b_vin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_din = tab_b[i].din;
      @(posedge clk); #1;
    end
    b_vin = 1'b0;
    chk("b_rdy_drop", b_rdy, 0);
    chk("b_gap_vo", b_vo, 0);
    maxv = 16'sh8000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("b_vo", b_vo, 1);
      chk("b_dout", b_dout, tab_b[k].dout);
      chk("b_bl", b_bl, tab_b[k].bl);
      chk("b_fl", b_fl, tab_b[k].fl);
      if ($signed(b_dout) > maxv) maxv = $signed(b_dout);
    end
    chk("b_rdy_back", b_rdy, 1);
    chk("b_pool_max", 32'(maxv), 32'(16'sh0133));
    @(posedge clk); #1;
    chk("b_post_vo", b_vo, 0);
    chk("b_post_hold", b_dout, 16'h00CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
Raster-to-window reorderer that produces the serial 2x2 block stream consumed by pooler_max2x2. It accepts one feature-map channel in raster order (row-major, Q8.8) and buffers one row pair. It then emits the pixels as consecutive groups of four per 2x2 window: top-left, top-right, bottom-left, bottom-right. It sits between a conv/ReLU output stage and the max pooler.

Parameters:
DATA_W, 16, pixel width (signed Q8.8)
IMG_W, 8, feature-map width in pixels; even, >=2
IMG_H, 8, feature-map height in rows; even, >=2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset)
valid_in  input  1  din valid
in_ready  output  1  block can accept din this cycle
din  input  DATA_W  signed raster-order input pixel
dout  output  DATA_W  signed reordered pixel
valid_out  output  1  dout valid
block_last  output  1  dout is 4th pixel of a 2x2 window
frame_last  output  1  dout is final pixel of the frame

Behaviour:
- Single clock domain; reset asynchronous active-low.
- Reset values: in_ready=1, valid_out=0, dout=0, block_last=0, frame_last=0. All counters are 0 and the FSM is in FILL.
- Storage: 2*IMG_W x DATA_W register buffer. Slots 0..IMG_W-1 hold the top row; slots IMG_W..2*IMG_W-1 hold the bottom row.
- Handshake: a pixel is accepted when valid_in && in_ready at a rising edge. valid_in while in_ready=0 is ignored, with no error and no buffering. Bubbles (valid_in=0) are allowed anywhere in FILL.
- FSM FILL:
  - in_ready=1.
  - Each accepted pixel is written to buf[wr_cnt], then wr_cnt increments.
  - The edge that accepts pixel 2*IMG_W-1 moves the FSM to DRAIN, drops in_ready, and clears wr_cnt.
- FSM DRAIN:
  - in_ready=0.
  - Read index k runs 0..2*IMG_W-1, one per cycle, with no output backpressure.
  - Decode: b=k>>2, q=k[1:0], addr = 2b + q[0] + (q[1] ? IMG_W : 0).
  - dout, valid_out, block_last and frame_last are registered. Beat k is visible in the cycle after the read.
  - The first valid_out is in the 2nd cycle after the accepting edge of the last pixel of the pair. valid_out stays high for exactly 2*IMG_W consecutive cycles.
  - block_last=1 when q==3.
  - frame_last=1 on beat k=2*IMG_W-1 of row pair IMG_H/2-1 only.
- DRAIN->FILL: on the edge that registers the final beat, in_ready=1 in the same cycle that beat is visible. Input accepted in that cycle is the next pair's pixel 0.
- Row-pair counter increments per completed DRAIN. It wraps to 0 after pair IMG_H/2-1, so back-to-back frames need no reset.
- Between beats valid_out=0, and dout holds its last value. block_last and frame_last are 0 whenever valid_out=0.
- Reset mid-FILL or mid-DRAIN: immediate abort, all outputs to reset values, partial data discarded, next accepted pixel is frame pixel 0. Buffer contents need not be cleared.
- Data passes unmodified: no arithmetic, sign preserved bit-exact.
- Throughput: 2*IMG_W accept cycles plus 2*IMG_W drain cycles per row pair. Drain gaps for pooler_max2x2 are whole-window aligned.

Test Plan:
- IMG_W=4, IMG_H=2; feed din=1..8 (0x0001..0x0008) contiguously:
  - Output order is 1,2,5,6,3,4,7,8.
  - block_last on the beats carrying 6 and 8.
  - frame_last only with 8.
  - valid_out high exactly 8 consecutive cycles, first beat 2 cycles after the edge accepting 8.
- Q8.8 values, IMG_W=2, IMG_H=2; input 0x0080, 0x0133, 0xFFB4, 0x00CC:
  - Outputs the same order, and 0xFFB4 (-0.3) is preserved bit-exact.
  - Chained to pooler_max2x2, the pooler output is 0x0133.
- Backpressure: hold valid_in=1 through DRAIN with din=0x7FFF:
  - No 0x7FFF appears in the current output; in_ready=0 throughout the drain.
  - The first 0x7FFF is accepted in the cycle the final beat is visible and appears as pixel 0 of the next pair.
- Bubbles: IMG_W=4, alternate valid_in 1/0 during FILL:
  - Output identical to the contiguous case.
  - Drain starts only after the 8th accepted pixel.
- Multi-frame: IMG_W=4, IMG_H=4, two frames back-to-back:
  - frame_last asserts exactly twice, at each frame's 16th output beat.
  - The row-pair counter wraps correctly.
- Reset: assert reset=0 asynchronously, mid-clock, after drain beat 3:
  - Outputs go 0 immediately and in_ready=1.
  - After release, a new 1..8 stream reproduces the first scenario exactly.
